// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate generator with a 2-entry skid buffer.
// Define IMM_SHIFT_EN to turn the branch (fmt 10) immediate into a word-aligned byte offset.
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [1:0]        in_fmt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        out_fmt
);
    typedef struct packed {
        logic [1:0]        fmt;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] imm;
    } ent_t;

    logic [1:0] cnt_q, cnt_d;
    ent_t       e0_q, e0_d, e1_q, e1_d, new_e;
    logic       push, pop;

    assign in_ready  = rst_n & (cnt_q != 2'd2);
    assign out_valid = cnt_q != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_imm   = e0_q.imm;
    assign out_tag   = e0_q.tag;
    assign out_fmt   = e0_q.fmt;

    // Extract and extend the immediate selected by the decoder's format code
    always_comb begin
        new_e.fmt = in_fmt;
        new_e.tag = in_tag;
        new_e.imm = in_fmt == 2'b00 ? DATA_W'($signed(in_instr[15:0])) :
                    in_fmt == 2'b01 ? DATA_W'($signed(in_instr[20:5])) :
`ifdef IMM_SHIFT_EN
                    in_fmt == 2'b10 ? DATA_W'($signed({in_instr[25:0], 2'b00})) :
`else
                    in_fmt == 2'b10 ? DATA_W'($signed(in_instr[25:0])) :
`endif
                                      DATA_W'(in_instr[15:0]);
    end

    // Head entry e0 drives the outputs directly; it is left untouched when the buffer drains
    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        e0_d  = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? new_e :
                (pop && cnt_q == 2'd2)                               ? e1_q  : e0_q;
        e1_d  = (push && cnt_q == 2'd1 && !pop) ? new_e : e1_q;
    end

    // Buffer state, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed and randomized checks of imm_ext_pipe against a queue model.
module tb_imm_ext_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_imm;
    logic [1:0]  in_fmt, out_fmt;
    logic [4:0]  in_tag, out_tag;
    logic        v64, r64, ov64;
    logic [31:0] i64;
    logic [63:0] o64;
    logic [4:0]  ot64;
    logic [1:0]  of64;
    int tests = 0, fails = 0;

    imm_ext_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_fmt(out_fmt));

    imm_ext_pipe #(.DATA_W(64)) u64 (.clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
        .in_instr(i64), .in_fmt(2'b00), .in_tag(5'd3), .out_valid(ov64), .out_ready(1'b1),
        .out_imm(o64), .out_tag(ot64), .out_fmt(of64));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [1:0] f, int w);
        longint v;
        int n;
        bit sx;
        case (f)
            2'b00: begin v = longint'(64'(ins[15:0])); n = 16; sx = 1; end
            2'b01: begin v = longint'(64'(ins[20:5])); n = 16; sx = 1; end
            2'b10: begin v = longint'(64'(ins[25:0])); n = 26; sx = 1; end
            default: begin v = longint'(64'(ins[15:0])); n = 16; sx = 0; end
        endcase
        if (sx && v >= (64'sd1 <<< (n - 1))) v = v - (64'sd1 <<< n);
`ifdef IMM_SHIFT_EN
        if (f == 2'b10) v = v * 4;
`endif
        return w == 64 ? 64'(v) : 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    typedef struct { logic [31:0] imm; logic [4:0] tag; logic [1:0] fmt; } ent_t;
    ent_t q[$];
    ent_t last;

    // Reference model: a FIFO of at most two entries, updated on each accepted handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last = '{0, 0, 0};
        end else begin
            bit pu, po;
            po = q.size() > 0 && out_ready;
            pu = in_valid && q.size() < 2;
            if (po) void'(q.pop_front());
            if (pu) q.push_back('{32'(ref_imm(in_instr, in_fmt, 32)), in_tag, in_fmt});
            if (q.size() > 0) last = q[0];
        end
    end

    // Compare DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(rst_n && q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(rst_n && q.size() < 2));
        check("out_imm", 64'(out_imm), 64'(last.imm));
        check("out_tag", 64'(out_tag), 64'(last.tag));
        check("out_fmt", 64'(out_fmt), 64'(last.fmt));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(logic [31:0] ins, logic [1:0] f, logic [4:0] t);
        in_valid = 1; in_instr = ins; in_fmt = f; in_tag = t;
    endtask

    logic [31:0] ins_t [4];
    logic [1:0]  fmt_t [4];
    logic [31:0] lit_t [4];

    initial begin
        ins_t = '{32'h0000FFFE, 32'h0000FFFE, 32'h001FFFE0, 32'h02000001};
        fmt_t = '{2'b00, 2'b11, 2'b01, 2'b10};
`ifdef IMM_SHIFT_EN
        lit_t = '{32'hFFFFFFFE, 32'h0000FFFE, 32'hFFFFFFFF, 32'hF8000004};
`else
        lit_t = '{32'hFFFFFFFE, 32'h0000FFFE, 32'hFFFFFFFF, 32'hFE000001};
`endif
        rst_n = 0; in_valid = 0; in_instr = 0; in_fmt = 0; in_tag = 0; out_ready = 0;
        v64 = 0; i64 = 0;
        repeat (3) tick();
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        #2 rst_n = 1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // format decode, back-to-back
        out_ready = 1;
        v64 = 1; i64 = 32'h00008000;
        for (int i = 0; i < 4; i++) begin
            check("model_lit", ref_imm(ins_t[i], fmt_t[i], 32), 64'(lit_t[i]));
            drive(ins_t[i], fmt_t[i], 5'(i + 1));
            tick();
            v64 = 0;
            check("fmt_imm", 64'(out_imm), 64'(lit_t[i]));
            check("fmt_tag", 64'(out_tag), 64'(i + 1));
            check("fmt_valid", 64'(out_valid), 64'd1);
            if (i == 0) begin
                check("w64_imm", o64, 64'hFFFFFFFFFFFF8000);
                check("w64_model", ref_imm(32'h00008000, 2'b00, 64), 64'hFFFFFFFFFFFF8000);
                check("w64_valid", 64'(ov64), 64'd1);
            end
        end
        in_valid = 0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("hold_last_imm", 64'(out_imm), 64'(lit_t[3]));

        // back-pressure
        out_ready = 0;
        drive($urandom, 2'($urandom), 5'd7); tick();
        drive($urandom, 2'($urandom), 5'd8); tick();
        drive($urandom, 2'($urandom), 5'd9); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_tag7", 64'(out_tag), 64'd7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1;
        tick();
        check("bp_tag8", 64'(out_tag), 64'd8);
        tick();
        check("bp_tag9", 64'(out_tag), 64'd9);
        in_valid = 0;
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // simultaneous push/pop at count 1
        drive($urandom, 2'($urandom), 5'd10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tp_valid", 64'(out_valid), 64'd1);
            check("tp_in_ready", 64'(in_ready), 64'd1);
            check("tp_tag", 64'(out_tag), 64'(10 + i));
            drive($urandom, 2'($urandom), 5'(11 + i));
        end
        in_valid = 0;
        tick();
        tick();

        // reset mid-operation
        out_ready = 0;
        drive($urandom, 2'($urandom), 5'd20); tick();
        drive($urandom, 2'($urandom), 5'd21); tick();
        in_valid = 0;
        check("mr_full_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 0;
        #1;
        check("mr_async_valid", 64'(out_valid), 64'd0);
        check("mr_async_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        #2 rst_n = 1;
        tick();
        drive($urandom, 2'($urandom), 5'd22);
        tick();
        in_valid = 0;
        out_ready = 1;
        check("mr_new_tag", 64'(out_tag), 64'd22);
        tick();
        check("mr_no_stale", 64'(out_valid), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom);
            in_instr = $urandom;
            in_fmt = 2'($urandom);
            in_tag = 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
